life_vga_timing: RTL and testbench
==================================

Name: life_vga_timing

Overview:
Raster timing generator for the Game of Life display path. It sits directly downstream of the 2:1 clock-enable divider and consumes its one-cycle-in-two pixel-enable pulse on the 50 MHz system clock, giving 25 MHz, 640x480@60 VGA timing. It produces sync, blanking, pixel and cell coordinates for the framebuffer/renderer. It also produces a frame-locked generation tick that paces the Life update engine.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
CELL_SHIFT, 4, log2 of cell size in pixels (16x16 cells)
GEN_FRAMES, 30, frames per Life generation (legal range 1..255)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
pix_en  in  1  pixel enable from the clock divider; one clk wide
run  in  1  1 = generation ticks enabled; 0 = paused
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
active  out  1  1 inside the visible region
x  out  10  pixel column; 0 when not active
y  out  10  pixel row; 0 when not active
cell_x  out  10-CELL_SHIFT  x >> CELL_SHIFT
cell_y  out  10-CELL_SHIFT  y >> CELL_SHIFT
frame_start  out  1  one-clk pulse at pixel (0,0)
gen_tick  out  1  one-clk pulse requesting one Life generation

Behaviour:
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- Counters: hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1 change only on clk edges where pix_en=1. With pix_en=0 all state and outputs hold, except the pulses, which clear.
- Counter update: hcnt wraps to 0 after H_TOTAL-1. vcnt increments only when hcnt wraps, and wraps to 0 after V_TOTAL-1.
- Reset (async, active-high): hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, frame counter fcnt=0. Outputs: hsync=1, vsync=1, active=0, x=y=cell_x=cell_y=0, frame_start=0, gen_tick=0.
- The first pix_en after reset release wraps the counters to (0,0).
- All outputs are registered and are computed from the next counter values. After the pix_en edge that loads (h,v), the outputs describe (h,v): zero latency relative to the counters.
- hsync=0 iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync=0 iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- active=1 iff hcnt<H_ACTIVE and vcnt<V_ACTIVE. Otherwise x, y, cell_x and cell_y are forced to 0.
- frame_start=1 for exactly one clk on the pix_en edge that loads (0,0), including the first one after reset. It is 0 on every other cycle.
- Generation pacing, evaluated on each frame_start:
  - run=1, fcnt==GEN_FRAMES-1: gen_tick=1 for that same clk; fcnt<=0.
  - run=1, otherwise: fcnt<=fcnt+1.
  - run=0: fcnt<=0, no gen_tick.
- Effect of pacing: after run rises, the first gen_tick comes on the GEN_FRAMES-th frame_start. GEN_FRAMES=1 ticks on every frame.
- run is sampled only at frame_start. Toggling run mid-frame has no effect until the next frame_start.
- If pix_en is held high continuously, timing simply runs at clk rate. No error handling is provided.
- Reset asserted mid-frame immediately forces the reset values above. Timing restarts cleanly from (0,0) on the first pix_en after release.

Test Plan:
- Reset, then pix_en every 2nd clk -> frame_start on the first pix_en edge. active=1, x=0, y=0. hsync=vsync=1.
- Line timing -> hsync falls at hcnt=656 (clk 1312 after the line start) and rises at hcnt=752. active falls at hcnt=640. Line period is 1600 clk.
- Frame timing -> vsync low for exactly 2 lines starting at line 490. Exactly 480 active lines. frame_start spacing is 840000 clk.
- Coordinates with CELL_SHIFT=4 -> at x=639, y=479: cell_x=39, cell_y=29. At hcnt=640: x=0, cell_x=0.
- Pacing with GEN_FRAMES=3, run=1 from reset -> gen_tick coincides with the 3rd, 6th and 9th frame_start. Then run=0 mid-frame 10 -> no tick at frame 12. Then run=1 before frame 13 -> next tick at frame 15.
- Async reset asserted at hcnt=700, vcnt=100 -> outputs take reset values in the same cycle without waiting for a clk edge. After release, the first pix_en gives frame_start=1 with x=y=0.

Source files
------------

// File: rtl/life_vga_timing.sv
// Raster timing generator for the Life display path: VGA sync, blanking,
// pixel/cell coordinates, frame start and frame-locked generation ticks.
module life_vga_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CELL_SHIFT = 4,
    parameter int GEN_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    input  logic                  run,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  active,
    output logic [9:0]            x,
    output logic [9:0]            y,
    output logic [9-CELL_SHIFT:0] cell_x,
    output logic [9-CELL_SHIFT:0] cell_y,
    output logic                  frame_start,
    output logic                  gen_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [7:0] GEN_LAST = 8'(GEN_FRAMES - 1);

    logic [9:0]            hcnt_q, hcnt_d;
    logic [9:0]            vcnt_q, vcnt_d;
    logic [7:0]            fcnt_q, fcnt_d;
    logic                  h_wrap;

    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  active_q, active_d;
    logic [9:0]            x_q, x_d;
    logic [9:0]            y_q, y_d;
    logic [9-CELL_SHIFT:0] cell_x_q, cell_x_d;
    logic [9-CELL_SHIFT:0] cell_y_q, cell_y_d;
    logic                  frame_start_q, frame_start_d;
    logic                  gen_tick_q, gen_tick_d;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        h_wrap = (hcnt_q == H_LAST);
        if (pix_en) begin
            hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
            if (h_wrap) begin
                vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
            end
        end
    end

    // Outputs are decoded from the next counter values so that the registered
    // outputs line up with the counters with no extra pipeline latency.
    always_comb begin
        active_d      = (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
        hsync_d       = !((hcnt_d >= HS_START) && (hcnt_d < HS_END));
        vsync_d       = !((vcnt_d >= VS_START) && (vcnt_d < VS_END));
        x_d           = active_d ? hcnt_d : 10'd0;
        y_d           = active_d ? vcnt_d : 10'd0;
        cell_x_d      = x_d[9:CELL_SHIFT];
        cell_y_d      = y_d[9:CELL_SHIFT];
        frame_start_d = pix_en && (hcnt_d == 10'd0) && (vcnt_d == 10'd0);
    end

    // Generation pacing only advances on a frame start; run is ignored otherwise.
    always_comb begin
        fcnt_d     = fcnt_q;
        gen_tick_d = 1'b0;
        if (frame_start_d) begin
            if (!run) begin
                fcnt_d = 8'd0;
            end else if (fcnt_q == GEN_LAST) begin
                fcnt_d     = 8'd0;
                gen_tick_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q        <= H_LAST;
            vcnt_q        <= V_LAST;
            fcnt_q        <= 8'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            cell_x_q      <= '0;
            cell_y_q      <= '0;
            frame_start_q <= 1'b0;
            gen_tick_q    <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            fcnt_q        <= fcnt_d;
            frame_start_q <= frame_start_d;
            gen_tick_q    <= gen_tick_d;
            if (pix_en) begin
                hsync_q  <= hsync_d;
                vsync_q  <= vsync_d;
                active_q <= active_d;
                x_q      <= x_d;
                y_q      <= y_d;
                cell_x_q <= cell_x_d;
                cell_y_q <= cell_y_d;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign cell_x      = cell_x_q;
    assign cell_y      = cell_y_q;
    assign frame_start = frame_start_q;
    assign gen_tick    = gen_tick_q;

endmodule

// File: tb/tb_life_vga_timing.sv
// Directed bench for life_vga_timing using a reduced raster (64x27 totals)
// so that many frames fit in a short run.
module tb_life_vga_timing;

    localparam int HT = 64;
    localparam int VT = 27;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic       run;
    logic       hsync, vsync, active, frame_start, gen_tick;
    logic [9:0] x, y;
    logic [5:0] cell_x, cell_y;

    int checks = 0;
    int passes = 0;
    int pcount = 0;

    life_vga_timing #(
        .H_ACTIVE(48), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CELL_SHIFT(4), .GEN_FRAMES(3)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .run(run),
        .hsync(hsync), .vsync(vsync), .active(active),
        .x(x), .y(y), .cell_x(cell_x), .cell_y(cell_y),
        .frame_start(frame_start), .gen_tick(gen_tick)
    );

    always #5 clk = ~clk;

    task automatic step(input logic en);
        @(negedge clk);
        pix_en = en;
        @(posedge clk);
        #1;
        if (en) pcount++;
    endtask

    // Move to raster position (h,v); slow mode pulses pix_en every 2nd clk.
    task automatic goto_pos(input int h, input int v, input bit fast);
        int t, cur, n;
        t = v * HT + h;
        if (pcount == 0) n = t + 1;
        else begin
            cur = (pcount - 1) % FT;
            n = (t - cur + FT) % FT;
        end
        repeat (n) begin
            if (fast) step(1'b1);
            else begin
                step(1'b0);
                step(1'b1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_en = 1'b0; run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hsync !== 1'b1) $display("[TB] FAIL rst_hsync got %b exp 1", hsync); else passes++;
        checks++; if (vsync !== 1'b1) $display("[TB] FAIL rst_vsync got %b exp 1", vsync); else passes++;
        checks++; if (active !== 1'b0) $display("[TB] FAIL rst_active got %b exp 0", active); else passes++;
        checks++; if (x !== 10'd0 || y !== 10'd0) $display("[TB] FAIL rst_xy got %0d,%0d exp 0,0", x, y); else passes++;
        checks++; if (cell_x !== 6'd0 || cell_y !== 6'd0) $display("[TB] FAIL rst_cell got %0d,%0d exp 0,0", cell_x, cell_y); else passes++;
        checks++; if (frame_start !== 1'b0 || gen_tick !== 1'b0) $display("[TB] FAIL rst_pulses got %b%b exp 00", frame_start, gen_tick); else passes++;
        @(negedge clk);
        rst = 1'b0;
        pcount = 0;
        step(1'b0);
        checks++; if (frame_start !== 1'b0) $display("[TB] FAIL idle_fs got %b exp 0", frame_start); else passes++;
        step(1'b1);
        checks++; if (frame_start !== 1'b1) $display("[TB] FAIL first_fs got %b exp 1", frame_start); else passes++;
        checks++; if (active !== 1'b1 || x !== 10'd0 || y !== 10'd0) $display("[TB] FAIL first_pix got a=%b x=%0d y=%0d exp 1,0,0", active, x, y); else passes++;
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) $display("[TB] FAIL first_sync got %b%b exp 11", hsync, vsync); else passes++;
        checks++; if (gen_tick !== 1'b0) $display("[TB] FAIL first_tick got %b exp 0", gen_tick); else passes++;
        step(1'b0);
        checks++; if (frame_start !== 1'b0) $display("[TB] FAIL fs_clear got %b exp 0", frame_start); else passes++;
        checks++; if (active !== 1'b1) $display("[TB] FAIL hold_active got %b exp 1", active); else passes++;
    endtask

    task automatic test_line();
        longint t1, t2;
        goto_pos(47, 0, 1'b0);
        checks++; if (active !== 1'b1 || x !== 10'd47 || cell_x !== 6'd2) $display("[TB] FAIL last_col got a=%b x=%0d cx=%0d exp 1,47,2", active, x, cell_x); else passes++;
        goto_pos(48, 0, 1'b0);
        checks++; if (active !== 1'b0 || x !== 10'd0 || cell_x !== 6'd0) $display("[TB] FAIL blank_col got a=%b x=%0d cx=%0d exp 0,0,0", active, x, cell_x); else passes++;
        goto_pos(51, 0, 1'b0);
        checks++; if (hsync !== 1'b1) $display("[TB] FAIL hs_pre got %b exp 1", hsync); else passes++;
        goto_pos(52, 0, 1'b0);
        checks++; if (hsync !== 1'b0) $display("[TB] FAIL hs_fall got %b exp 0", hsync); else passes++;
        goto_pos(57, 0, 1'b0);
        checks++; if (hsync !== 1'b0) $display("[TB] FAIL hs_last got %b exp 0", hsync); else passes++;
        goto_pos(58, 0, 1'b0);
        checks++; if (hsync !== 1'b1) $display("[TB] FAIL hs_rise got %b exp 1", hsync); else passes++;
        goto_pos(0, 1, 1'b0);
        t1 = $time;
        checks++; if (active !== 1'b1 || y !== 10'd1 || frame_start !== 1'b0) $display("[TB] FAIL line1 got a=%b y=%0d fs=%b exp 1,1,0", active, y, frame_start); else passes++;
        goto_pos(0, 2, 1'b0);
        t2 = $time;
        checks++; if (t2 - t1 != 64'd1280) $display("[TB] FAIL line_period got %0d exp 1280", t2 - t1); else passes++;
    endtask

    task automatic test_pix_en_hold();
        goto_pos(10, 2, 1'b0);
        repeat (3) step(1'b0);
        checks++; if (x !== 10'd10 || y !== 10'd2 || active !== 1'b1) $display("[TB] FAIL hold got x=%0d y=%0d a=%b exp 10,2,1", x, y, active); else passes++;
    endtask

    task automatic test_coords();
        goto_pos(47, 19, 1'b0);
        checks++; if (x !== 10'd47 || y !== 10'd19) $display("[TB] FAIL corner_xy got %0d,%0d exp 47,19", x, y); else passes++;
        checks++; if (cell_x !== 6'd2 || cell_y !== 6'd1) $display("[TB] FAIL corner_cell got %0d,%0d exp 2,1", cell_x, cell_y); else passes++;
        goto_pos(48, 19, 1'b0);
        checks++; if (active !== 1'b0 || x !== 10'd0 || y !== 10'd0 || cell_y !== 6'd0) $display("[TB] FAIL hblank got a=%b x=%0d y=%0d cy=%0d exp 0,0,0,0", active, x, y, cell_y); else passes++;
        goto_pos(5, 20, 1'b0);
        checks++; if (active !== 1'b0 || x !== 10'd0 || y !== 10'd0) $display("[TB] FAIL vblank got a=%b x=%0d y=%0d exp 0,0,0", active, x, y); else passes++;
        goto_pos(63, 21, 1'b0);
        checks++; if (vsync !== 1'b1) $display("[TB] FAIL vs_pre got %b exp 1", vsync); else passes++;
        goto_pos(0, 22, 1'b0);
        checks++; if (vsync !== 1'b0) $display("[TB] FAIL vs_fall got %b exp 0", vsync); else passes++;
        goto_pos(63, 23, 1'b0);
        checks++; if (vsync !== 1'b0) $display("[TB] FAIL vs_last got %b exp 0", vsync); else passes++;
        goto_pos(0, 24, 1'b0);
        checks++; if (vsync !== 1'b1) $display("[TB] FAIL vs_rise got %b exp 1", vsync); else passes++;
    endtask

    task automatic test_frame();
        longint t2, t3;
        int act_lines, vs_lines, first_vs;
        goto_pos(0, 0, 1'b0);
        t2 = $time;
        checks++; if (frame_start !== 1'b1 || gen_tick !== 1'b0) $display("[TB] FAIL frame2 got fs=%b gt=%b exp 1,0", frame_start, gen_tick); else passes++;
        act_lines = 0; vs_lines = 0; first_vs = -1;
        for (int v = 0; v < VT; v++) begin
            if (v != 0) goto_pos(0, v, 1'b0);
            if (active === 1'b1) act_lines++;
            if (vsync === 1'b0) begin
                vs_lines++;
                if (first_vs < 0) first_vs = v;
            end
        end
        checks++; if (act_lines != 20) $display("[TB] FAIL active_lines got %0d exp 20", act_lines); else passes++;
        checks++; if (vs_lines != 2 || first_vs != 22) $display("[TB] FAIL vsync_lines got %0d from %0d exp 2 from 22", vs_lines, first_vs); else passes++;
        goto_pos(0, 0, 1'b0);
        t3 = $time;
        checks++; if (t3 - t2 != 64'd34560) $display("[TB] FAIL frame_period got %0d exp 34560", t3 - t2); else passes++;
        checks++; if (frame_start !== 1'b1 || gen_tick !== 1'b1) $display("[TB] FAIL frame3_tick got fs=%b gt=%b exp 1,1", frame_start, gen_tick); else passes++;
        step(1'b1);
        checks++; if (gen_tick !== 1'b0 || frame_start !== 1'b0) $display("[TB] FAIL tick_clear got gt=%b fs=%b exp 0,0", gen_tick, frame_start); else passes++;
    endtask

    task automatic test_pacing();
        logic exp_tick;
        for (int f = 4; f <= 15; f++) begin
            exp_tick = (f == 6 || f == 9 || f == 15);
            goto_pos(0, 0, 1'b1);
            checks++; if (frame_start !== 1'b1 || gen_tick !== exp_tick) $display("[TB] FAIL pace_f%0d got fs=%b gt=%b exp 1,%b", f, frame_start, gen_tick, exp_tick); else passes++;
            step(1'b1);
            if (f == 10) begin
                goto_pos(30, 5, 1'b1);
                run = 1'b0;
            end else if (f == 12) begin
                goto_pos(30, 5, 1'b1);
                run = 1'b1;
            end else if (f == 13) begin
                goto_pos(10, 3, 1'b1);
                run = 1'b0;
                goto_pos(20, 3, 1'b1);
                run = 1'b1;
            end
        end
    endtask

    task automatic test_async_reset();
        goto_pos(20, 5, 1'b1);
        checks++; if (active !== 1'b1 || x !== 10'd20 || y !== 10'd5) $display("[TB] FAIL pre_rst got a=%b x=%0d y=%0d exp 1,20,5", active, x, y); else passes++;
        #1;
        rst = 1'b1;
        pix_en = 1'b0;
        #1;
        checks++; if (active !== 1'b0 || x !== 10'd0 || y !== 10'd0 || cell_x !== 6'd0) $display("[TB] FAIL async_rst got a=%b x=%0d y=%0d cx=%0d exp 0,0,0,0", active, x, y, cell_x); else passes++;
        @(negedge clk);
        rst = 1'b0;
        pcount = 0;
        step(1'b0);
        checks++; if (frame_start !== 1'b0) $display("[TB] FAIL post_rst_idle got %b exp 0", frame_start); else passes++;
        step(1'b1);
        checks++; if (frame_start !== 1'b1 || x !== 10'd0 || y !== 10'd0 || gen_tick !== 1'b0) $display("[TB] FAIL post_rst_fs got fs=%b x=%0d y=%0d gt=%b exp 1,0,0,0", frame_start, x, y, gen_tick); else passes++;
        goto_pos(53, 23, 1'b1);
        checks++; if (hsync !== 1'b0 || vsync !== 1'b0) $display("[TB] FAIL pre_rst_sync got %b%b exp 00", hsync, vsync); else passes++;
        #1;
        rst = 1'b1;
        pix_en = 1'b0;
        #1;
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) $display("[TB] FAIL async_rst_sync got %b%b exp 11", hsync, vsync); else passes++;
        @(negedge clk);
        rst = 1'b0;
        pcount = 0;
        step(1'b1);
        checks++; if (frame_start !== 1'b1 || active !== 1'b1 || x !== 10'd0) $display("[TB] FAIL restart got fs=%b a=%b x=%0d exp 1,1,0", frame_start, active, x); else passes++;
    endtask

    initial begin
        test_reset();
        test_line();
        test_pix_en_hold();
        test_coords();
        test_frame();
        test_pacing();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
